data_mem_ctrl: RTL and testbench

Data-memory controller that terminates the vector CPU's memory port (memAddress / memDataInput / readEn / writeEn in, dataMem out). It holds the data RAM (combinational read, synchronous write) and a memory-mapped output FIFO. Stores from the MEM stage push results, for example packed pixel words, into that FIFO. A downstream consumer (display / UART bridge) drains the FIFO through a valid/ready handshake.

---
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word RAM (combinational read, synchronous write) plus a
// memory-mapped output FIFO drained by a valid/ready consumer, with sticky status flags.
module data_mem_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_in,
  input  logic        read_en,
  input  logic        write_en,
  output logic [31:0] data_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // Word addresses (byte address >> 2) of the two registers.
  localparam logic [29:0] PUSH_WORD   = 30'h3FFF_FFC0;
  localparam logic [29:0] STATUS_WORD = 30'h3FFF_FFC1;

  logic [31:0]   ram  [DEPTH];
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          range_err;

  logic [AW-1:0] ram_index;
  logic          is_ram;
  logic          is_push;
  logic          is_status;
  logic          is_unmapped;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          drop;
  logic          clr_overflow;
  logic          clr_range_err;
  logic          set_range_err;
  logic [7:0]    count_byte;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  assign ram_index   = mem_address[AW+1:2];
  assign is_ram      = (mem_address[31:AW+2] == '0);
  assign is_push     = (mem_address[31:2] == PUSH_WORD);
  assign is_status   = (mem_address[31:2] == STATUS_WORD);
  assign is_unmapped = !is_ram && !is_push && !is_status;
  // Byte-lane bits carry no meaning for word accesses.
  assign unused_addr_bits = &{1'b0, mem_address[1:0]};

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = !empty;
  assign out_data  = out_valid ? fifo[rd_ptr] : '0;

  assign pop      = out_valid && out_ready;
  assign push_req = write_en && is_push;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign clr_overflow  = write_en && is_status && mem_data_in[2];
  assign clr_range_err = write_en && is_status && mem_data_in[3];
  assign set_range_err = (read_en || write_en) && is_unmapped;

  assign count_byte  = 8'(count);
  assign status_word = {16'h0000, count_byte, 4'h0, range_err, overflow, full, empty};

  always_comb begin
    data_mem = '0;
    if (read_en) begin
      if (is_ram) begin
        data_mem = ram[ram_index];
      end else if (is_status) begin
        data_mem = status_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
      // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
      overflow  <= drop || (overflow && !clr_overflow);
      range_err <= set_range_err || (range_err && !clr_range_err);
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (write_en && is_ram) begin
      ram[ram_index] <= mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo[wr_ptr] <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, hand-written reset sequence and
// randomized traffic checked against a queue-based reference model.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;
  localparam int FD    = 8;
  localparam logic [31:0] PUSH = 32'hFFFF_FF00;
  localparam logic [31:0] STAT = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_data_in = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] data_mem;
  logic [31:0] out_data;
  logic        out_valid;

  data_mem_ctrl #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .read_en    (read_en),
    .write_en   (write_en),
    .data_mem   (data_mem),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: RAM as an array, FIFO as a queue, flags as bits.
  logic [31:0] m_ram [DEPTH];
  logic [31:0] m_q [$];
  bit          m_ovf;
  bit          m_rerr;

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          rdy;
    logic [31:0] dm;
    bit          v;
    logic [31:0] od;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit re, bit we, logic [31:0] addr, logic [31:0] wd, bit rdy,
                              logic [31:0] dm, bit v, logic [31:0] od);
    vec_t r;
    r.re = re; r.we = we; r.addr = addr; r.wd = wd; r.rdy = rdy;
    r.dm = dm; r.v = v; r.od = od;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_in_ram(logic [31:0] a);
    return a < 32'(DEPTH * 4);
  endfunction

  function automatic bit m_at(logic [31:0] a, logic [31:0] reg_addr);
    return (a >> 2) == (reg_addr >> 2);
  endfunction

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {16'h0000, 8'(n), 4'h0, m_rerr, m_ovf, (n == FD), (n == 0)};
  endfunction

  function automatic logic [31:0] m_dm(bit re, logic [31:0] a);
    if (!re) return 32'h0;
    if (m_in_ram(a)) return m_ram[int'(a >> 2)];
    if (m_at(a, STAT)) return m_status();
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_rerr = 1'b0;
  endtask

  task automatic model_edge(bit re, bit we, logic [31:0] a, logic [31:0] wd, bit rdy);
    bit pop      = (m_q.size() != 0) && rdy;
    bit was_full = (m_q.size() == FD);
    bit unmapped = !m_in_ram(a) && !m_at(a, PUSH) && !m_at(a, STAT);
    bit n_ovf    = m_ovf;
    bit n_rerr   = m_rerr;
    if (we && m_in_ram(a)) m_ram[int'(a >> 2)] = wd;
    if (we && m_at(a, STAT) && wd[2]) n_ovf = 1'b0;
    if (we && m_at(a, STAT) && wd[3]) n_rerr = 1'b0;
    if (we && m_at(a, PUSH) && was_full && !pop) n_ovf = 1'b1;
    if ((re || we) && unmapped) n_rerr = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (we && m_at(a, PUSH) && (!was_full || pop)) m_q.push_back(wd);
    m_ovf  = n_ovf;
    m_rerr = n_rerr;
  endtask

  // One transaction: drive, compare outputs mid-cycle, clock, advance the model.
  task automatic apply(bit re, bit we, logic [31:0] a, logic [31:0] wd, bit rdy,
                       bit use_tab, logic [31:0] e_dm, bit e_v, logic [31:0] e_od, string tag);
    logic [31:0] x_dm;
    logic [31:0] x_od;
    bit          x_v;
    read_en = re; write_en = we; mem_address = a; mem_data_in = wd; out_ready = rdy;
    #2;
    if (use_tab) begin
      x_dm = e_dm; x_v = e_v; x_od = e_od;
    end else begin
      x_dm = m_dm(re, a);
      x_v  = (m_q.size() != 0);
      x_od = x_v ? m_q[0] : 32'h0;
    end
    $display("%s re=%0b we=%0b addr=%h wd=%h rdy=%0b | dm=%h v=%0b od=%h", tag, re, we, a, wd,
             rdy, data_mem, out_valid, out_data);
    check({tag, " data_mem"}, data_mem, x_dm);
    check({tag, " out_valid"}, {31'h0, out_valid}, {31'h0, x_v});
    check({tag, " out_data"}, out_data, x_od);
    @(posedge clk);
    model_edge(re, we, a, wd, rdy);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, observed while rst is still low.
    read_en = 1'b1; mem_address = STAT;
    #3;
    check("reset status", data_mem, 32'h0000_0001);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset out_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b1; read_en = 1'b0;
    m_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, 1'b1, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "init");
    end

    tab.push_back(mk(0, 1, 'h10, 'hDEADBEEF, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 'h10, 0, 0, 'hDEADBEEF, 0, 0));
    tab.push_back(mk(1, 0, 'h14, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, PUSH, 1, 0, 0, 0, 0));
    for (int k = 2; k <= 8; k++) tab.push_back(mk(0, 1, PUSH, 32'(k), 0, 0, 1, 1));
    tab.push_back(mk(1, 0, STAT, 0, 0, 'h802, 1, 1));
    tab.push_back(mk(0, 1, PUSH, 9, 0, 0, 1, 1));
    tab.push_back(mk(1, 0, STAT, 0, 0, 'h806, 1, 1));
    tab.push_back(mk(1, 1, STAT, 4, 0, 'h806, 1, 1));
    tab.push_back(mk(1, 0, STAT, 0, 0, 'h802, 1, 1));
    tab.push_back(mk(0, 1, PUSH, 'hAA, 1, 0, 1, 1));
    tab.push_back(mk(1, 0, STAT, 0, 1, 'h802, 1, 2));
    for (int k = 3; k <= 8; k++) tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'(k)));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 'hAA));
    tab.push_back(mk(1, 0, STAT, 0, 1, 1, 0, 0));
    tab.push_back(mk(1, 0, 'h8000_0000, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, STAT, 0, 0, 9, 0, 0));
    tab.push_back(mk(0, 1, STAT, 8, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, STAT, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 1, 'h8000_0000, 8, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, STAT, 0, 0, 9, 0, 0));
    tab.push_back(mk(0, 1, STAT, 8, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 'h20, 'h11, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 'h20, 'h22, 0, 'h11, 0, 0));
    tab.push_back(mk(1, 0, 'h20, 0, 0, 'h22, 0, 0));
    tab.push_back(mk(0, 1, 'hFC, 'h1234_5678, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 'hFC, 0, 0, 'h1234_5678, 0, 0));
    tab.push_back(mk(0, 1, 'h100, 'h5555, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 'h0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, STAT, 0, 0, 9, 0, 0));
    tab.push_back(mk(0, 1, STAT, 'hC, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 'h13, 0, 0, 'hDEADBEEF, 0, 0));
    tab.push_back(mk(1, 0, PUSH, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, STAT, 0, 0, 1, 0, 0));

    foreach (tab[i]) begin
      apply(tab[i].re, tab[i].we, tab[i].addr, tab[i].wd, tab[i].rdy, 1'b1,
            tab[i].dm, tab[i].v, tab[i].od, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a cycle with a push pending.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, PUSH, 32'(48 + k), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "pre-rst push");
    end
    read_en = 1'b0; write_en = 1'b1; mem_address = PUSH; mem_data_in = 32'h99; out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async out_valid", {31'h0, out_valid}, 32'h0);
    write_en = 1'b0; read_en = 1'b1; mem_address = STAT;
    #1;
    check("async status", data_mem, 32'h0000_0001);
    check("async out_data", out_data, 32'h0);
    $display("async reset: dm=%h v=%0b od=%h", data_mem, out_valid, out_data);
    @(negedge clk);
    rst = 1'b1; read_en = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    apply(1'b0, 1'b1, PUSH, 32'h5, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, "post-rst push");
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h5, "post-rst data");

    // Randomized traffic; consumer readiness varies by phase so the FIFO fills and drains.
    for (int i = 0; i < 1500; i++) begin
      int unsigned k = $urandom_range(0, 9);
      int unsigned rdy_pct = ((i / 250) % 2 == 0) ? 20 : 80;
      logic [31:0] a;
      logic [31:0] wd = $urandom;
      bit re  = 1'($urandom_range(0, 1));
      bit we  = 1'($urandom_range(0, 1));
      bit rdy = ($urandom_range(0, 99) < rdy_pct);
      case (k)
        0, 1, 2, 3: a = 32'(($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3));
        4, 5, 6:    a = PUSH | 32'($urandom_range(0, 3));
        7:          a = STAT;
        8: begin
          case ($urandom_range(0, 3))
            0:       a = 32'(DEPTH * 4);
            1:       a = 32'h8000_0000;
            2:       a = 32'hFFFF_FF08;
            default: a = 32'hFFFF_FEFC;
          endcase
        end
        default: a = $urandom;
      endcase
      apply(re, we, a, wd, rdy, 1'b0, 32'h0, 1'b0, 32'h0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
